// File: rtl/data_break_arbiter_pkg.sv
// Shared constants, FSM encoding and small helpers for the data-break arbiter.
package data_break_arbiter_pkg;

  localparam int NREQ_DFLT    = 4;
  localparam int TIMEOUT_DFLT = 255;
  localparam int PTR_W        = 2;
  localparam int ADDR_W       = 15;
  localparam int WCNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BRK  = 2'd2,
    ST_DONE = 2'd3
  } dba_state_e;

  // Increment that sticks at all-ones so the wait counter can never wrap.
  function automatic logic [WCNT_W-1:0] sat_inc(input logic [WCNT_W-1:0] v);
    logic [WCNT_W-1:0] r;
    r = (v == {WCNT_W{1'b1}}) ? v : v + WCNT_W'(1);
    return r;
  endfunction

  // Index of the set bit in a one-hot vector (bit 0 is device 0).
  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [0:NREQ_DFLT-1] oh);
    logic [PTR_W-1:0] r;
    r = {PTR_W{1'b0}};
    for (int i = 0; i < NREQ_DFLT; i++) begin
      r = r | ({PTR_W{oh[i]}} & PTR_W'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/data_break_arbiter_if.sv
// Requester / state-machine side bundle of the data-break arbiter.
interface data_break_arbiter_if;
  import data_break_arbiter_pkg::*;

  logic [0:NREQ_DFLT-1]        req;
  logic [0:NREQ_DFLT*ADDR_W-1] req_addr;
  logic [0:NREQ_DFLT-1]        req_to_mem;
  logic                        break_in_prog;
  logic                        data_break;
  logic                        to_disk;
  logic [0:ADDR_W-1]           dmaAddr;
  logic [0:NREQ_DFLT-1]        grant;
  logic [0:NREQ_DFLT-1]        done;
  logic                        err;

  modport master (
    output req, req_addr, req_to_mem, break_in_prog,
    input  data_break, to_disk, dmaAddr, grant, done, err
  );

  modport slave (
    input  req, req_addr, req_to_mem, break_in_prog,
    output data_break, to_disk, dmaAddr, grant, done, err
  );

endinterface

// File: rtl/data_break_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr wins.
module data_break_arbiter_rr_pick
  import data_break_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT
) (
  input  logic [0:NREQ-1]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [0:NREQ-1]  gnt,
  output logic             valid
);

  logic [PTR_W-1:0] idx_s;

  // Scan devices in ptr order; only the first requester seen gets the grant.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx_s = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx_s      = ptr + PTR_W'(i);
      gnt[idx_s] = req[idx_s] & ~valid;
      valid      = valid | req[idx_s];
    end
  end

endmodule

// File: rtl/data_break_arbiter.sv
// Data-break arbiter: shares the state machine's break cycle among four
// DMA devices with round-robin fairness, a stall timeout and a CLEAR abort.
module data_break_arbiter
  import data_break_arbiter_pkg::*;
#(
  parameter int NREQ    = NREQ_DFLT,
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  data_break_arbiter_if.slave  bus
);

  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

  dba_state_e        state_r;
  logic [PTR_W-1:0]  ptr_r;
  logic [PTR_W-1:0]  win_r;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic              clear_pend_r;
  logic              data_break_r;
  logic              to_disk_r;
  logic [0:ADDR_W-1] dma_addr_r;
  logic [0:NREQ-1]   grant_r;
  logic [0:NREQ-1]   done_r;
  logic              err_r;

  logic [0:NREQ-1]   pick_gnt_s;
  logic              pick_valid_s;
  logic [PTR_W-1:0]  pick_idx_s;
  logic [0:ADDR_W-1] addr_sel_s;
  logic              dir_sel_s;
  logic [WCNT_W-1:0] wait_next_s;

  data_break_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (bus.req),
    .ptr   (ptr_r),
    .gnt   (pick_gnt_s),
    .valid (pick_valid_s)
  );

  assign pick_idx_s  = onehot_to_idx(pick_gnt_s);
  assign dir_sel_s   = bus.req_to_mem[pick_idx_s];
  assign wait_next_s = sat_inc(wait_cnt_r);

  // Route the winning device's 15-bit address slot to the latch input.
  always_comb begin
    addr_sel_s = '0;
    case (pick_idx_s)
      2'd0:    addr_sel_s = bus.req_addr[0:14];
      2'd1:    addr_sel_s = bus.req_addr[15:29];
      2'd2:    addr_sel_s = bus.req_addr[30:44];
      2'd3:    addr_sel_s = bus.req_addr[45:59];
      default: addr_sel_s = '0;
    endcase
  end

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      win_r        <= '0;
      wait_cnt_r   <= '0;
      clear_pend_r <= 1'b0;
      data_break_r <= 1'b0;
      to_disk_r    <= 1'b0;
      dma_addr_r   <= '0;
      grant_r      <= '0;
      done_r       <= '0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wait_cnt_r <= '0;
          if (clear) begin
            err_r <= 1'b0;
          end else if (pick_valid_s) begin
            state_r      <= ST_REQ;
            grant_r      <= pick_gnt_s;
            win_r        <= pick_idx_s;
            dma_addr_r   <= addr_sel_s;
            to_disk_r    <= dir_sel_s;
            data_break_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (clear) begin
            // Abort before the memory cycle starts; ptr is left alone.
            state_r      <= ST_IDLE;
            data_break_r <= 1'b0;
            grant_r      <= '0;
            err_r        <= 1'b0;
            wait_cnt_r   <= '0;
          end else if (bus.break_in_prog) begin
            state_r      <= ST_BRK;
            data_break_r <= 1'b0;
          end else if (wait_next_s >= TIMEOUT_C) begin
            // Stalled: give up on this device and move ptr past it.
            state_r      <= ST_IDLE;
            data_break_r <= 1'b0;
            grant_r      <= '0;
            err_r        <= 1'b1;
            ptr_r        <= win_r + PTR_W'(1);
            wait_cnt_r   <= '0;
          end else begin
            wait_cnt_r <= wait_next_s;
          end
        end
        ST_BRK: begin
          // The memory cycle is never cut short; remember CLEAR for later.
          if (clear) begin
            clear_pend_r <= 1'b1;
          end
          if (!bus.break_in_prog) begin
            state_r <= ST_DONE;
            done_r  <= grant_r;
          end
        end
        ST_DONE: begin
          state_r      <= ST_IDLE;
          done_r       <= '0;
          grant_r      <= '0;
          ptr_r        <= win_r + PTR_W'(1);
          clear_pend_r <= 1'b0;
          if (clear || clear_pend_r) begin
            err_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          data_break_r <= 1'b0;
          grant_r      <= '0;
          done_r       <= '0;
          clear_pend_r <= 1'b0;
          wait_cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bus.data_break = data_break_r;
  assign bus.to_disk    = to_disk_r;
  assign bus.dmaAddr    = dma_addr_r;
  assign bus.grant      = grant_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_data_break_arbiter.sv
// Self-checking bench for data_break_arbiter: directed scenarios plus random
// breaks, checked against a transaction-level round-robin model.
module tb_data_break_arbiter;

  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   n_checks = 0;
  int   n_err    = 0;
  int   ptr_m    = 0;
  bit   err_m    = 1'b0;

  data_break_arbiter_if bus();

  data_break_arbiter #(.NREQ(4), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First requesting device at or after ptr, wrapping mod 4.
  function automatic int rr_expect(input logic [0:3] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  function automatic logic [0:3] onehot(input int d);
    logic [0:3] v;
    v = 4'b0000;
    v[d] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:14] slot_addr(input logic [0:59] a, input int d);
    logic [0:14] r;
    for (int j = 0; j < 15; j++) r[j] = a[15 * d + j];
    return r;
  endfunction

  task automatic randomize_bus();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    bus.req_addr   = t[59:0];
    bus.req_to_mem = 4'($urandom());
  endtask

  // One complete break: grant, optional stall in REQ, BRK, DONE, idle gap.
  task automatic do_break(input logic [0:3] reqs, input int stall, input int bip_len,
                          input bit disturb, input bit clear_brk, input string nm);
    int          w;
    logic [0:3]  g;
    logic [0:14] a;
    logic        d;
    w = rr_expect(reqs, ptr_m);
    g = onehot(w);
    a = slot_addr(bus.req_addr, w);
    d = bus.req_to_mem[w];
    bus.req = reqs;
    tick();
    chk({nm, "/db_rise"}, 32'(bus.data_break), 32'd1);
    chk({nm, "/grant"},   32'(bus.grant),      32'(g));
    chk({nm, "/addr"},    32'(bus.dmaAddr),    32'(a));
    chk({nm, "/to_disk"}, 32'(bus.to_disk),    32'(d));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({nm, "/db_stall"}, 32'(bus.data_break), 32'd1);
    end
    bus.break_in_prog = 1'b1;
    tick();
    chk({nm, "/db_brk"}, 32'(bus.data_break), 32'd0);
    clear = clear_brk;
    if (disturb) begin
      randomize_bus();
      bus.req[w] = 1'b0;
    end
    for (int i = 1; i < bip_len; i++) begin
      tick();
      clear = 1'b0;
      chk({nm, "/done_brk"}, 32'(bus.done),    32'd0);
      chk({nm, "/addr_brk"}, 32'(bus.dmaAddr), 32'(a));
    end
    bus.break_in_prog = 1'b0;
    tick();
    clear = 1'b0;
    chk({nm, "/done"},      32'(bus.done),    32'(g));
    chk({nm, "/grant_dn"},  32'(bus.grant),   32'(g));
    chk({nm, "/addr_dn"},   32'(bus.dmaAddr), 32'(a));
    chk({nm, "/to_dsk_dn"}, 32'(bus.to_disk), 32'(d));
    bus.req = 4'b0000;
    tick();
    chk({nm, "/done_end"},  32'(bus.done),       32'd0);
    chk({nm, "/grant_end"}, 32'(bus.grant),      32'd0);
    chk({nm, "/db_end"},    32'(bus.data_break), 32'd0);
    if (clear_brk) err_m = 1'b0;
    chk({nm, "/err"}, 32'(bus.err), 32'(err_m));
    ptr_m = (w + 1) % 4;
  endtask

  // Grant then never start the break; optionally CLEAR on the timeout edge.
  task automatic do_timeout(input logic [0:3] reqs, input bit with_clear, input string nm);
    int w;
    int cnt;
    bit seen_done;
    w = rr_expect(reqs, ptr_m);
    bus.req = reqs;
    bus.break_in_prog = 1'b0;
    tick();
    chk({nm, "/grant"},   32'(bus.grant),      32'(onehot(w)));
    chk({nm, "/db_rise"}, 32'(bus.data_break), 32'd1);
    cnt = 1;
    seen_done = 1'b0;
    for (int i = 0; i < TIMEOUT + 40; i++) begin
      if (with_clear && cnt == TIMEOUT) clear = 1'b1;
      tick();
      clear = 1'b0;
      if (bus.done !== 4'b0000) seen_done = 1'b1;
      if (bus.data_break === 1'b1) cnt++;
      else break;
    end
    bus.req = 4'b0000;
    chk({nm, "/db_cycles"}, 32'(cnt),            32'(TIMEOUT));
    chk({nm, "/no_done"},   32'(seen_done),      32'd0);
    chk({nm, "/db_low"},    32'(bus.data_break), 32'd0);
    chk({nm, "/grant_low"}, 32'(bus.grant),      32'd0);
    if (with_clear) begin
      err_m = 1'b0;
    end else begin
      err_m = 1'b1;
      ptr_m = (w + 1) % 4;
    end
    chk({nm, "/err"}, 32'(bus.err), 32'(err_m));
  endtask

  initial begin
    logic [0:3] r;
    reset = 1'b1;
    clear = 1'b0;
    bus.req = 4'b0000;
    bus.req_addr = '0;
    bus.req_to_mem = 4'b0000;
    bus.break_in_prog = 1'b0;
    tick();
    tick();
    chk("rst/db",      32'(bus.data_break), 32'd0);
    chk("rst/grant",   32'(bus.grant),      32'd0);
    chk("rst/done",    32'(bus.done),       32'd0);
    chk("rst/addr",    32'(bus.dmaAddr),    32'd0);
    chk("rst/to_disk", 32'(bus.to_disk),    32'd0);
    chk("rst/err",     32'(bus.err),        32'd0);
    reset = 1'b0;
    tick();

    // Single request from device 3 at address 0x1234.
    randomize_bus();
    bus.req_addr[45:59] = 15'h1234;
    bus.req_to_mem = 4'b0001;
    do_break(4'b0001, 0, 3, 1'b0, 1'b0, "single");

    // Fairness with every device requesting; fifth break proves ptr wrapped to 0.
    for (int k = 0; k < 5; k++) begin
      randomize_bus();
      do_break(4'b1111, 1, 2, 1'b0, 1'b0, "fair");
    end

    // Timeout on device 1, then the next grant moves on to device 2.
    do_timeout(4'b0100, 1'b0, "tmo");
    randomize_bus();
    do_break(4'b0110, 0, 2, 1'b0, 1'b0, "after_tmo");

    // CLEAR in IDLE drops the sticky error.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    err_m = 1'b0;
    chk("clr_idle/err", 32'(bus.err),        32'd0);
    chk("clr_idle/db",  32'(bus.data_break), 32'd0);

    // CLEAR in REQ aborts the grant and keeps ptr.
    randomize_bus();
    bus.req = 4'b1010;
    tick();
    chk("clr_req/db0",    32'(bus.data_break), 32'd1);
    chk("clr_req/grant0", 32'(bus.grant),      32'(onehot(rr_expect(4'b1010, ptr_m))));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.req = 4'b0000;
    chk("clr_req/db",    32'(bus.data_break), 32'd0);
    chk("clr_req/grant", 32'(bus.grant),      32'd0);
    chk("clr_req/err",   32'(bus.err),        32'd0);
    tick();
    chk("clr_req/idle", 32'(bus.data_break), 32'd0);
    randomize_bus();
    do_break(4'b1010, 2, 1, 1'b0, 1'b0, "after_clr");

    // CLEAR on the very edge the timeout fires: CLEAR wins.
    do_timeout(4'b0011, 1'b1, "tmo_clr");

    // CLEAR during BRK with err set: break completes, err then clears.
    do_timeout(4'b1000, 1'b0, "tmo2");
    randomize_bus();
    do_break(4'b1001, 0, 3, 1'b1, 1'b1, "clr_brk");

    // Reset while waiting in REQ.
    randomize_bus();
    bus.req = 4'b0010;
    tick();
    chk("rst_req/db0", 32'(bus.data_break), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req = 4'b0000;
    ptr_m = 0;
    err_m = 1'b0;
    chk("rst_req/db",      32'(bus.data_break), 32'd0);
    chk("rst_req/grant",   32'(bus.grant),      32'd0);
    chk("rst_req/done",    32'(bus.done),       32'd0);
    chk("rst_req/addr",    32'(bus.dmaAddr),    32'd0);
    chk("rst_req/to_disk", 32'(bus.to_disk),    32'd0);
    chk("rst_req/err",     32'(bus.err),        32'd0);
    tick();
    chk("rst_req/done2", 32'(bus.done), 32'd0);
    randomize_bus();
    do_break(4'b1111, 0, 1, 1'b0, 1'b0, "after_rst");

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      randomize_bus();
      r = 4'($urandom_range(1, 15));
      do_break(r, int'($urandom_range(0, 4)), int'($urandom_range(1, 5)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
